// File: rtl/axis_rr_packet_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXI-Stream egress between N_SRC sources.
// Grants are held until tlast is accepted; a watchdog releases a grant whose source stalls mid-packet.
module axis_rr_packet_arbiter #(
    parameter int unsigned N_SRC      = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEST_WIDTH = 4,
    parameter int unsigned USER_WIDTH = 4,
    parameter int unsigned ID_WIDTH   = 2,
    parameter int unsigned STALL_MAX  = 255
) (
    input  logic                             clk,
    input  logic                             resn,
    input  logic                             enable,
    input  logic [N_SRC-1:0]                 s_tvalid,
    output logic [N_SRC-1:0]                 s_tready,
    input  logic [N_SRC-1:0]                 s_tlast,
    input  logic [N_SRC*DATA_WIDTH-1:0]      s_tdata,
    input  logic [N_SRC*DEST_WIDTH-1:0]      s_tdest,
    input  logic [N_SRC*USER_WIDTH-1:0]      s_tuser,
    output logic                             m_tvalid,
    input  logic                             m_tready,
    output logic                             m_tlast,
    output logic [DATA_WIDTH-1:0]            m_tdata,
    output logic [DEST_WIDTH-1:0]            m_tdest,
    output logic [USER_WIDTH-1:0]            m_tuser,
    output logic [ID_WIDTH-1:0]              m_tid,
    output logic                             busy,
    output logic                             err_stall
);

    localparam int unsigned SEL_W = $clog2(N_SRC);
    localparam int unsigned CNT_W = $clog2(STALL_MAX + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] grant_q, grant_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [SEL_W-1:0] next_ptr;
    logic [SEL_W-1:0] pick;
    logic             found;
    int unsigned      idx;

    assign busy      = (state_q == S_BUSY);
    assign m_tid     = busy ? ID_WIDTH'(grant_q) : '0;
    assign next_ptr  = (grant_q == SEL_W'(N_SRC - 1)) ? '0 : grant_q + SEL_W'(1);
    assign err_stall = busy && !m_tvalid && (stall_cnt_q == CNT_W'(STALL_MAX - 1));

    // Zero-latency passthrough of the granted source; everything idles low otherwise.
    always_comb begin
        s_tready = '0;
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;
        m_tdata  = '0;
        m_tdest  = '0;
        m_tuser  = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (busy && (grant_q == SEL_W'(i))) begin
                s_tready[i] = m_tready;
                m_tvalid    = s_tvalid[i];
                m_tlast     = s_tlast[i];
                m_tdata     = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                m_tdest     = s_tdest[i*DEST_WIDTH +: DEST_WIDTH];
                m_tuser     = s_tuser[i*USER_WIDTH +: USER_WIDTH];
            end
        end
    end

    // Next-state: round-robin pick in IDLE, packet lock and stall watchdog in BUSY.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        stall_cnt_d = stall_cnt_q;
        found       = 1'b0;
        pick        = '0;
        idx         = '0;
        case (state_q)
            S_IDLE: begin
                stall_cnt_d = '0;
                if (enable) begin
                    for (int unsigned k = 0; k < N_SRC; k++) begin
                        idx = 32'(rr_ptr_q) + k;
                        if (idx >= N_SRC) idx = idx - N_SRC;
                        if (!found && s_tvalid[SEL_W'(idx)]) begin
                            found = 1'b1;
                            pick  = SEL_W'(idx);
                        end
                    end
                end
                if (found) begin
                    state_d = S_BUSY;
                    grant_d = pick;
                end
            end
            S_BUSY: begin
                stall_cnt_d = m_tvalid ? '0 : stall_cnt_q + CNT_W'(1);
                if ((m_tvalid && m_tready && m_tlast) || err_stall) begin
                    state_d     = S_IDLE;
                    rr_ptr_d    = next_ptr;
                    stall_cnt_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_axis_rr_packet_arbiter.sv
// Scoreboard bench for axis_rr_packet_arbiter: per-source beat queues drive the inputs,
// expected egress beats are queued in predicted grant order and checked on every handshake.
module tb_axis_rr_packet_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned TW = 4;
    localparam int unsigned UW = 4;
    localparam int unsigned IW = 2;
    localparam int unsigned SM = 4;

    logic            clk = 1'b0;
    logic            resn = 1'b0;
    logic            enable = 1'b1;
    logic [N-1:0]    s_tvalid = '0;
    logic [N-1:0]    s_tready;
    logic [N-1:0]    s_tlast = '0;
    logic [N*DW-1:0] s_tdata = '0;
    logic [N*TW-1:0] s_tdest = '0;
    logic [N*UW-1:0] s_tuser = '0;
    logic            m_tvalid;
    logic            m_tready = 1'b0;
    logic            m_tlast;
    logic [DW-1:0]   m_tdata;
    logic [TW-1:0]   m_tdest;
    logic [UW-1:0]   m_tuser;
    logic [IW-1:0]   m_tid;
    logic            busy;
    logic            err_stall;

    axis_rr_packet_arbiter #(
        .N_SRC(N), .DATA_WIDTH(DW), .DEST_WIDTH(TW), .USER_WIDTH(UW),
        .ID_WIDTH(IW), .STALL_MAX(SM)
    ) dut (
        .clk(clk), .resn(resn), .enable(enable),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
        .s_tdata(s_tdata), .s_tdest(s_tdest), .s_tuser(s_tuser),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
        .m_tdata(m_tdata), .m_tdest(m_tdest), .m_tuser(m_tuser),
        .m_tid(m_tid), .busy(busy), .err_stall(err_stall)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IW-1:0] tid;
        logic [DW-1:0] data;
        logic [TW-1:0] dest;
        logic [UW-1:0] user;
        logic          last;
    } beat_t;

    beat_t        src_q[N][$];
    beat_t        exp_q[$];
    int           compared = 0;
    int           mismatched = 0;
    int           cyc = 0;
    int           last_acc_cyc = 0;
    int           err_cyc = 0;
    int           err_cnt = 0;
    logic [N-1:0] hs = '0;
    bit           mr_toggle = 1'b0;
    logic         mr_level = 1'b1;

    // Source and sink driver: retire handshaken beats, present the next queued beat.
    initial begin
        beat_t b;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            for (int i = 0; i < N; i++) begin
                if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
                if (src_q[i].size() > 0) begin
                    b = src_q[i][0];
                    s_tvalid[i] = 1'b1;
                    s_tlast[i]  = b.last;
                    s_tdata[i*DW +: DW] = b.data;
                    s_tdest[i*TW +: TW] = b.dest;
                    s_tuser[i*UW +: UW] = b.user;
                end else begin
                    s_tvalid[i] = 1'b0;
                    s_tlast[i]  = 1'b0;
                end
            end
            m_tready = mr_toggle ? ~m_tready : mr_level;
        end
    end

    // Egress monitor and scoreboard; a handshake seen here completes on the next rising edge.
    initial begin
        beat_t e;
        beat_t got;
        forever begin
            @(negedge clk);
            hs = s_tvalid & s_tready;
            if (err_stall) begin
                err_cnt++;
                err_cyc = cyc + 1;
            end
            if (resn && m_tvalid && m_tready) begin
                last_acc_cyc = cyc + 1;
                got = beat_t'({m_tid, m_tdata, m_tdest, m_tuser, m_tlast});
                compared++;
                if (exp_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL sb_unexpected: got beat %h, required no beat", got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        mismatched++;
                        $display("FAIL sb_beat: got %h (tid=%0d data=%h last=%b), required %h (tid=%0d data=%h last=%b)",
                                 got, got.tid, got.data, got.last, e, e.tid, e.data, e.last);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1, "timeout");
    end

    task automatic load_pkt(input int src, input int pkt, input int nb, input bit with_last);
        beat_t x;
        for (int b = 0; b < nb; b++) begin
            x.tid  = IW'(src);
            x.data = DW'((src << 6) | (pkt << 3) | b);
            x.dest = TW'(b + src);
            x.user = UW'(15 - src);
            x.last = with_last && (b == nb - 1);
            src_q[src].push_back(x);
            exp_q.push_back(x);
        end
    endtask

    task automatic wait_exp(input int target, input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < max_cyc; k++) begin
            if (exp_q.size() <= target) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        bit ok;
        for (int s = 0; s < N; s++) load_pkt(s, 0, 1, 1'b1);
        @(negedge clk);
        @(negedge clk);
        compared++;
        if (s_tready !== '0) begin mismatched++; $display("FAIL rst_tready: got %b, required 0000", s_tready); end
        compared++;
        if (m_tvalid !== 1'b0) begin mismatched++; $display("FAIL rst_tvalid: got %b, required 0", m_tvalid); end
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("FAIL rst_busy: got %b, required 0", busy); end
        compared++;
        if (m_tid !== '0) begin mismatched++; $display("FAIL rst_tid: got %0d, required 0", m_tid); end
        resn = 1'b1;
        @(negedge clk);
        compared++;
        if (busy !== 1'b1 || m_tid !== '0) begin
            mismatched++;
            $display("FAIL rst_first_grant: got busy=%b tid=%0d, required busy=1 tid=0", busy, m_tid);
        end
        wait_exp(0, 50, ok);
        compared++;
        if (!ok) begin mismatched++; $display("FAIL rst_drain: got %0d beats left, required 0", exp_q.size()); end
    endtask

    task automatic test_round_robin();
        bit ok;
        int start;
        repeat (2) @(negedge clk);
        start = cyc;
        load_pkt(0, 1, 3, 1'b1);
        load_pkt(1, 1, 3, 1'b1);
        load_pkt(2, 1, 3, 1'b1);
        load_pkt(3, 1, 3, 1'b1);
        load_pkt(0, 2, 3, 1'b1);
        wait_exp(0, 100, ok);
        compared++;
        if (!ok) begin mismatched++; $display("FAIL rr_drain: got %0d beats left, required 0", exp_q.size()); end
        // One cycle for the driver to present, then 5 packets of 1 bubble + 3 beats.
        compared++;
        if (last_acc_cyc - start != 21) begin
            mismatched++;
            $display("FAIL rr_cycles: got %0d, required 21", last_acc_cyc - start);
        end
    endtask

    task automatic test_packet_lock();
        bit ok;
        repeat (2) @(negedge clk);
        mr_toggle = 1'b1;
        load_pkt(0, 3, 5, 1'b1);
        for (int k = 0; k < 10 && !busy; k++) @(negedge clk);
        compared++;
        if (busy !== 1'b1 || m_tid !== 2'd0) begin
            mismatched++;
            $display("FAIL lock_grant: got busy=%b tid=%0d, required busy=1 tid=0", busy, m_tid);
        end
        load_pkt(1, 3, 3, 1'b1);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (busy && m_tid == 2'd0) begin
                compared++;
                if (s_tready[1] !== 1'b0) begin
                    mismatched++;
                    $display("FAIL lock_tready1: got %b, required 0", s_tready[1]);
                end
            end
        end
        wait_exp(0, 100, ok);
        compared++;
        if (!ok) begin mismatched++; $display("FAIL lock_drain: got %0d beats left, required 0", exp_q.size()); end
        mr_toggle = 1'b0;
        mr_level  = 1'b1;
    endtask

    task automatic test_watchdog();
        bit ok;
        int err0;
        int t2;
        repeat (4) @(negedge clk);
        err0 = err_cnt;
        load_pkt(2, 4, 2, 1'b0);
        load_pkt(3, 4, 2, 1'b1);
        wait_exp(2, 50, ok);
        t2 = last_acc_cyc;
        compared++;
        if (!ok) begin mismatched++; $display("FAIL wd_src2: got %0d beats left, required 2", exp_q.size()); end
        wait_exp(0, 100, ok);
        compared++;
        if (!ok) begin mismatched++; $display("FAIL wd_drain: got %0d beats left, required 0", exp_q.size()); end
        compared++;
        if (err_cnt - err0 != 1) begin
            mismatched++;
            $display("FAIL wd_pulses: got %0d, required 1", err_cnt - err0);
        end
        compared++;
        if (err_cyc - t2 != 4) begin
            mismatched++;
            $display("FAIL wd_delay: got %0d, required 4", err_cyc - t2);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int err0;
        repeat (2) @(negedge clk);
        err0 = err_cnt;
        mr_level = 1'b0;
        @(negedge clk);
        load_pkt(1, 5, 3, 1'b1);
        repeat (20) @(negedge clk);
        compared++;
        if (busy !== 1'b1 || exp_q.size() != 3) begin
            mismatched++;
            $display("FAIL bp_hold: got busy=%b left=%0d, required busy=1 left=3", busy, exp_q.size());
        end
        compared++;
        if (err_cnt != err0) begin mismatched++; $display("FAIL bp_no_err: got %0d pulses, required 0", err_cnt - err0); end
        mr_level = 1'b1;
        wait_exp(0, 50, ok);
        compared++;
        if (!ok) begin mismatched++; $display("FAIL bp_drain: got %0d beats left, required 0", exp_q.size()); end
        compared++;
        if (err_cnt != err0) begin mismatched++; $display("FAIL bp_no_err_end: got %0d pulses, required 0", err_cnt - err0); end
    endtask

    task automatic test_enable();
        bit ok;
        repeat (4) @(negedge clk);
        load_pkt(2, 6, 2, 1'b1);
        load_pkt(3, 6, 2, 1'b1);
        load_pkt(0, 6, 2, 1'b1);
        load_pkt(1, 6, 2, 1'b1);
        load_pkt(2, 7, 2, 1'b1);
        @(negedge clk);
        @(negedge clk);
        compared++;
        if (busy !== 1'b1 || m_tid !== 2'd2) begin
            mismatched++;
            $display("FAIL en_grant: got busy=%b tid=%0d, required busy=1 tid=2", busy, m_tid);
        end
        enable = 1'b0;
        wait_exp(8, 20, ok);
        repeat (10) @(negedge clk);
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("FAIL en_idle: got busy=%b, required 0", busy); end
        compared++;
        if (exp_q.size() != 8) begin mismatched++; $display("FAIL en_held: got %0d beats left, required 8", exp_q.size()); end
        enable = 1'b1;
        wait_exp(0, 100, ok);
        compared++;
        if (!ok) begin mismatched++; $display("FAIL en_drain: got %0d beats left, required 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_packet_lock();
        test_watchdog();
        test_backpressure();
        test_enable();
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
